fifo_access_arb: RTL and testbench

- Single-clock access controller that shares one 16-bit x 512 FIFO storage block between N_WR producers and N_RD consumers.
- Each cycle it issues at most one FIFO operation, write or read, never both; the storage ignores simultaneous write and read.
- Round-robin within each direction; a burst limit gives fairness between directions.
- Sits between client ports and the FIFO's wen/ren/enable/din/dout/full/empty interface.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/fifo_access_arb.sv | 136 +++++++++++++
 tb/tb_fifo_access_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO access arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_dir_e;

  localparam int MAX_CLIENTS = 8;

  // Pointer width for an index in 0..n-1; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after the pointer wins;
// the pointer moves past the winner only when the grant is actually taken.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = ptr_w(N);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] win_idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr_reg) + k) % N]) begin
        found                          = 1'b1;
        gnt[(int'(ptr_reg) + k) % N]   = 1'b1;
        win_idx                        = PW'((int'(ptr_reg) + k) % N);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && found) begin
      ptr_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/fifo_access_arb.sv
// Shares one FIFO between N_WR producers and N_RD consumers, issuing at most
// one write or read per cycle with burst-limited fairness between directions.
module fifo_access_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_WR   = 2,
  parameter int N_RD   = 2,
  parameter int BURST  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_WR-1:0]          wr_req,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  output logic [N_WR-1:0]          wr_gnt,
  input  logic [N_RD-1:0]          rd_req,
  output logic [N_RD-1:0]          rd_gnt,
  output logic [N_RD-1:0]          rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     fifo_en,
  output logic                     fifo_wen,
  output logic                     fifo_ren,
  output logic [DATA_W-1:0]        fifo_din,
  input  logic [DATA_W-1:0]        fifo_dout,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic [1:0]               arb_state
);

  localparam int BW = ptr_w(BURST + 1);

  arb_dir_e             state_reg;
  arb_dir_e             state_next;
  arb_dir_e             dir;
  logic [BW-1:0]        burst_cnt_reg;
  logic [BW-1:0]        burst_cnt_next;
  logic                 we;
  logic                 re;
  logic                 wr_sel;
  logic                 rd_sel;
  logic [N_WR-1:0]      wr_arb_gnt;
  logic [N_RD-1:0]      rd_arb_gnt;
  logic [N_RD-1:0]      rd_valid_reg;
  logic [DATA_W-1:0]    din_terms [N_WR];

  assign we = (|wr_req) && !fifo_full;
  assign re = (|rd_req) && !fifo_empty;

  // Direction is forced idle during reset so no strobe escapes while rst is low.
  always_comb begin
    dir = ARB_IDLE;
    if (we && re) begin
      case (state_reg)
        ARB_WR:  dir = (burst_cnt_reg < BW'(BURST)) ? ARB_WR : ARB_RD;
        ARB_RD:  dir = (burst_cnt_reg < BW'(BURST)) ? ARB_RD : ARB_WR;
        default: dir = ARB_RD;
      endcase
    end else if (we) begin
      dir = ARB_WR;
    end else if (re) begin
      dir = ARB_RD;
    end
    if (!rst) begin
      dir = ARB_IDLE;
    end
  end

  always_comb begin
    state_next     = dir;
    burst_cnt_next = '0;
    if (dir == ARB_IDLE) begin
      burst_cnt_next = '0;
    end else if (dir == state_reg) begin
      burst_cnt_next = (burst_cnt_reg == BW'(BURST)) ? burst_cnt_reg
                                                      : burst_cnt_reg + 1'b1;
    end else begin
      burst_cnt_next = BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ARB_IDLE;
      burst_cnt_reg <= '0;
      rd_valid_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      rd_valid_reg  <= rd_gnt;
    end
  end

  assign wr_sel = (dir == ARB_WR);
  assign rd_sel = (dir == ARB_RD);

  rr_arbiter #(.N(N_WR)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (wr_sel),
    .gnt     (wr_arb_gnt)
  );

  rr_arbiter #(.N(N_RD)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .advance (rd_sel),
    .gnt     (rd_arb_gnt)
  );

  assign wr_gnt = wr_sel ? wr_arb_gnt : '0;
  assign rd_gnt = rd_sel ? rd_arb_gnt : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_WR; gi++) begin : g_din
      assign din_terms[gi] = wr_gnt[gi] ? wr_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < N_WR; i++) begin
      fifo_din = fifo_din | din_terms[i];
    end
  end

  assign fifo_wen  = wr_sel;
  assign fifo_ren  = rd_sel;
  assign fifo_en   = wr_sel | rd_sel;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = fifo_dout;
  assign arb_state = state_reg;

endmodule

// File: tb/tb_fifo_access_arb.sv
// Directed bench for fifo_access_arb with a behavioural 16x512 FIFO attached.
module tb_fifo_access_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  wr_req;
  logic [31:0] wr_data;
  logic [1:0]  wr_gnt;
  logic [1:0]  rd_req;
  logic [1:0]  rd_gnt;
  logic [1:0]  rd_valid;
  logic [15:0] rd_data;
  logic        fifo_en;
  logic        fifo_wen;
  logic        fifo_ren;
  logic [15:0] fifo_din;
  logic [15:0] fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  arb_state;

  int checks = 0;
  int errors = 0;

  fifo_access_arb #(.DATA_W(16), .N_WR(2), .N_RD(2), .BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_en    (fifo_en),
    .fifo_wen   (fifo_wen),
    .fifo_ren   (fifo_ren),
    .fifo_din   (fifo_din),
    .fifo_dout  (fifo_dout),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .arb_state  (arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO storage, reset from the same source as the arbiter.
  logic [15:0] mem [512];
  logic [8:0]  wp;
  logic [8:0]  rp;
  int          cnt;
  logic        do_w;
  logic        do_r;

  assign do_w       = fifo_en && fifo_wen && (cnt < 512);
  assign do_r       = fifo_en && fifo_ren && (cnt > 0);
  assign fifo_full  = (cnt == 512);
  assign fifo_empty = (cnt == 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 0;
      wp        <= '0;
      rp        <= '0;
      fifo_dout <= '0;
    end else begin
      if (do_w) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 9'd1;
      end
      if (do_r) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 9'd1;
      end
      cnt <= cnt + (do_w ? 1 : 0) - (do_r ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [1:0]  exp_state;
  logic        rp_exp;
  logic        wp_exp;
  logic        is_rd;

  initial begin
    rst     = 1'b0;
    wr_req  = 2'b00;
    rd_req  = 2'b00;
    wr_data = {16'hB000, 16'hA000};

    // Reset held: random requests must not produce any strobe.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_req = 2'($urandom_range(1, 3));
      rd_req = 2'($urandom_range(0, 3));
      #1;
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_fifo_en", fifo_en, 0);
      chk("rst_wen_ren", {fifo_wen, fifo_ren}, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_state", arb_state, 0);
    end

    // Write fairness until full; the first step also releases reset.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      rst    = 1'b1;
      wr_req = 2'b11;
      rd_req = 2'b00;
      #1;
      chk("wr_gnt_alt", wr_gnt, (i % 2) ? 2 : 1);
      chk("wr_din", fifo_din, (i % 2) ? 16'hB000 : 16'hA000);
      chk("wr_strobes", {fifo_en, fifo_wen, fifo_ren}, 3'b110);
      chk("wr_state", arb_state, (i == 0) ? 0 : 1);
    end
    @(negedge clk);
    #1;
    chk("full_flag", fifo_full, 1);
    chk("full_no_wr_gnt", wr_gnt, 0);
    chk("full_no_en", fifo_en, 0);

    // Full with both requests: read first, then the freed slot is written.
    @(negedge clk);
    wr_req          = 2'b01;
    wr_data[15:0]   = 16'hC000;
    rd_req          = 2'b01;
    #1;
    chk("full_rd_gnt", rd_gnt, 1);
    chk("full_wr_blocked", wr_gnt, 0);
    chk("full_rd_strobes", {fifo_en, fifo_wen, fifo_ren}, 3'b101);
    @(negedge clk);
    rd_req = 2'b00;
    #1;
    chk("after_rd_wr_gnt", wr_gnt, 1);
    chk("after_rd_din", fifo_din, 16'hC000);
    chk("rd_valid_lat1", rd_valid, 1);
    chk("rd_data_first", rd_data, 16'hA000);
    chk("state_rd", arb_state, 2);

    // Read stream, then reset asserted between edges.
    @(negedge clk);
    wr_req = 2'b00;
    rd_req = 2'b11;
    #1;
    chk("stream_rd_gnt0", rd_gnt, 2);
    chk("stream_state_wr", arb_state, 1);
    @(negedge clk);
    #1;
    chk("stream_rd_gnt1", rd_gnt, 1);
    chk("stream_valid0", rd_valid, 2);
    chk("stream_data0", rd_data, 16'hB000);
    @(negedge clk);
    #1;
    chk("stream_valid1", rd_valid, 1);
    chk("stream_data1", rd_data, 16'hA000);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_gnt", rd_gnt, 0);
    chk("midrst_fifo_en", fifo_en, 0);
    chk("midrst_state", arb_state, 0);
    @(negedge clk);
    #1;
    chk("midrst_hold_valid", rd_valid, 0);

    // Release; both pointers restart at 0.
    @(negedge clk);
    rst           = 1'b1;
    wr_req        = 2'b01;
    wr_data[15:0] = 16'h1234;
    rd_req        = 2'b00;
    #1;
    chk("post_rst_wr_gnt", wr_gnt, 1);
    chk("post_rst_empty", fifo_empty, 1);
    chk("post_rst_state", arb_state, 0);
    @(negedge clk);
    wr_req = 2'b00;
    rd_req = 2'b10;
    #1;
    chk("lat_rd_gnt", rd_gnt, 2);
    chk("lat_ren", fifo_ren, 1);
    @(negedge clk);
    rd_req = 2'b00;
    #1;
    chk("lat_rd_valid", rd_valid, 2);
    chk("lat_rd_data", rd_data, 16'h1234);
    chk("lat_no_gnt", rd_gnt, 0);

    // Empty FIFO blocks reads.
    @(negedge clk);
    rd_req = 2'b01;
    #1;
    chk("empty_flag", fifo_empty, 1);
    chk("empty_no_rd_gnt", rd_gnt, 0);
    chk("empty_no_en", fifo_en, 0);

    // Load 100 words, idle one cycle, then run both directions flat out.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rd_req  = 2'b00;
      wr_req  = 2'b01;
      wr_data = {16'h0000, 16'(i)};
      #1;
      if (i == 0) chk("fill_wr_gnt", wr_gnt, 1);
    end
    @(negedge clk);
    wr_req = 2'b00;
    #1;
    chk("idle_no_en", fifo_en, 0);

    exp_state = 2'd0;
    rp_exp    = 1'b0;
    wp_exp    = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      wr_req = 2'b11;
      rd_req = 2'b11;
      #1;
      is_rd = (((k / 4) % 2) == 0);
      chk("bal_state", arb_state, exp_state);
      chk("bal_ren", fifo_ren, is_rd);
      chk("bal_wen", fifo_wen, !is_rd);
      chk("bal_excl", fifo_wen & fifo_ren, 0);
      if (is_rd) begin
        chk("bal_rd_gnt", rd_gnt, rp_exp ? 2 : 1);
        chk("bal_wr_idle", wr_gnt, 0);
        rp_exp = ~rp_exp;
        exp_state = 2'd2;
      end else begin
        chk("bal_wr_gnt", wr_gnt, wp_exp ? 2 : 1);
        chk("bal_rd_idle", rd_gnt, 0);
        wp_exp = ~wp_exp;
        exp_state = 2'd1;
      end
    end

    @(negedge clk);
    wr_req = 2'b00;
    rd_req = 2'b00;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
